wb_stage: RTL and testbench

- Write-back stage of the 5-stage 16-bit pipeline.
- Holds the MEM/WB pipeline register and selects the write-back value by memToReg.
- Drives the register-file write port of the decode stage: write enable, destination register, write data.
- Tracks halt/error end-of-program states and counts retired instructions for the testbench dump.

---
 rtl/wb_stage_if.sv | 37 +++
 rtl/wb_stage.sv | 90 +++++++++
 tb/tb_wb_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM->WB bundle and write-back results for the 16-bit pipeline's final stage.
// The master side feeds MEM-stage fields; the slave side is the write-back stage itself.
interface wb_stage_if #(
    parameter int RCNT_W = 32
);
    logic              mem_valid;
    logic              mem_regWrite;
    logic [2:0]        mem_write_reg;
    logic [1:0]        mem_memToReg;
    logic [15:0]       mem_alu_res;
    logic [15:0]       mem_read_data;
    logic [15:0]       mem_pc_inc;
    logic [15:0]       mem_imm;
    logic              mem_halt;
    logic              mem_err;
    logic              stall;
    logic              flush;
    logic              wb_regWrite;
    logic [2:0]        wb_write_reg;
    logic [15:0]       wb_write_data;
    logic              halt;
    logic              createdump;
    logic              err;
    logic [RCNT_W-1:0] retired;

    modport master (
        output mem_valid, mem_regWrite, mem_write_reg, mem_memToReg, mem_alu_res,
               mem_read_data, mem_pc_inc, mem_imm, mem_halt, mem_err, stall, flush,
        input  wb_regWrite, wb_write_reg, wb_write_data, halt, createdump, err, retired
    );

    modport slave (
        input  mem_valid, mem_regWrite, mem_write_reg, mem_memToReg, mem_alu_res,
               mem_read_data, mem_pc_inc, mem_imm, mem_halt, mem_err, stall, flush,
        output wb_regWrite, wb_write_reg, wb_write_data, halt, createdump, err, retired
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, write-data select, end-of-program FSM
// and a saturating retired-instruction counter.
module wb_stage #(
    parameter int RCNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_stage_if.slave    bus
);
    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic [2:0]  write_reg;
        logic [1:0]  memToReg;
        logic [15:0] alu_res;
        logic [15:0] read_data;
        logic [15:0] pc_inc;
        logic [15:0] imm;
        logic        halt;
        logic        err;
    } memwb_t;

    typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, ERROR = 2'd2} state_t;

    memwb_t            r;
    state_t            state, state_nxt;
    logic [RCNT_W-1:0] retired;
    logic              run, retire_now;
    logic [15:0]       wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else if (bus.flush) begin
            r.valid <= 1'b0;
        end else if (!bus.stall) begin
            r.valid     <= bus.mem_valid;
            r.regWrite  <= bus.mem_regWrite;
            r.write_reg <= bus.mem_write_reg;
            r.memToReg  <= bus.mem_memToReg;
            r.alu_res   <= bus.mem_alu_res;
            r.read_data <= bus.mem_read_data;
            r.pc_inc    <= bus.mem_pc_inc;
            r.imm       <= bus.mem_imm;
            r.halt      <= bus.mem_halt;
            r.err       <= bus.mem_err;
        end
    end

    assign run = (state == RUN);
    // A held entry retires only when it actually leaves WB (advance or flush),
    // so a multi-cycle stall still counts it once.
    assign retire_now = r.valid & run & (~bus.stall | bus.flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == RUN && retire_now) begin
            if (r.err)       state_nxt = ERROR;
            else if (r.halt) state_nxt = HALTED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           retired <= '0;
        else if (retire_now && retired != '1) retired <= retired + 1'b1;
    end

    always_comb begin
        wdata = r.alu_res;
        case (r.memToReg)
            2'b00:   wdata = r.alu_res;
            2'b01:   wdata = r.read_data;
            2'b10:   wdata = r.pc_inc;
            default: wdata = r.imm;
        endcase
    end

    assign bus.wb_regWrite   = r.valid & r.regWrite & ~r.halt & ~r.err & run;
    assign bus.wb_write_reg  = r.write_reg;
    assign bus.wb_write_data = wdata;
    assign bus.halt          = ~run | (r.valid & run & (r.halt | r.err));
    assign bus.err           = (state == ERROR) | (r.valid & run & r.err);
    assign bus.createdump    = retire_now & r.halt & ~r.err;
    assign bus.retired       = retired;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; a second RCNT_W=4 instance shares the stimulus
// to exercise counter saturation.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wb_stage_if #(.RCNT_W(32)) bus  ();
    wb_stage_if #(.RCNT_W(4))  bus4 ();

    wb_stage #(.RCNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    wb_stage #(.RCNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    assign bus4.mem_valid     = bus.mem_valid;
    assign bus4.mem_regWrite  = bus.mem_regWrite;
    assign bus4.mem_write_reg = bus.mem_write_reg;
    assign bus4.mem_memToReg  = bus.mem_memToReg;
    assign bus4.mem_alu_res   = bus.mem_alu_res;
    assign bus4.mem_read_data = bus.mem_read_data;
    assign bus4.mem_pc_inc    = bus.mem_pc_inc;
    assign bus4.mem_imm       = bus.mem_imm;
    assign bus4.mem_halt      = bus.mem_halt;
    assign bus4.mem_err       = bus.mem_err;
    assign bus4.stall         = bus.stall;
    assign bus4.flush         = bus.flush;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [2:0] wr,
                         input logic [1:0] m2r, input logic hl, input logic er);
        bus.mem_valid     = v;
        bus.mem_regWrite  = rw;
        bus.mem_write_reg = wr;
        bus.mem_memToReg  = m2r;
        bus.mem_alu_res   = 16'h1234;
        bus.mem_read_data = 16'hBEEF;
        bus.mem_pc_inc    = 16'h0042;
        bus.mem_imm       = 16'hFFF8;
        bus.mem_halt      = hl;
        bus.mem_err       = er;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(0, 0, 3'd0, 2'b00, 0, 0);
        #2;
        chk("rst_we",    {31'd0, bus.wb_regWrite}, 32'd0);
        chk("rst_wreg",  {29'd0, bus.wb_write_reg}, 32'd0);
        chk("rst_wdata", {16'd0, bus.wb_write_data}, 32'd0);
        chk("rst_flags", {29'd0, bus.halt, bus.createdump, bus.err}, 32'd0);
        chk("rst_ret",   bus.retired, 32'd0);
        step();
        rst = 1'b0;

        // load with memToReg=01
        drive(1, 1, 3'd3, 2'b01, 0, 0);
        step();
        drive(0, 0, 3'd0, 2'b00, 0, 0);
        chk("ld_we",    {31'd0, bus.wb_regWrite}, 32'd1);
        chk("ld_wreg",  {29'd0, bus.wb_write_reg}, 32'd3);
        chk("ld_wdata", {16'd0, bus.wb_write_data}, 32'hBEEF);
        step();
        chk("ld_ret",    bus.retired, 32'd1);
        chk("bubble_we", {31'd0, bus.wb_regWrite}, 32'd0);

        // remaining write-back sources
        drive(1, 1, 3'd1, 2'b00, 0, 0);
        step();
        chk("m2r00", {16'd0, bus.wb_write_data}, 32'h1234);
        drive(1, 1, 3'd1, 2'b10, 0, 0);
        step();
        chk("m2r10", {16'd0, bus.wb_write_data}, 32'h0042);
        drive(1, 1, 3'd1, 2'b11, 0, 0);
        step();
        chk("m2r11", {16'd0, bus.wb_write_data}, 32'hFFF8);
        chk("m2r_ret", bus.retired, 32'd3);
        drive(0, 0, 3'd0, 2'b00, 0, 0);
        step();
        chk("seq_ret", bus.retired, 32'd4);

        // stall holds the entry and it retires once
        drive(1, 1, 3'd5, 2'b00, 0, 0);
        step();
        bus.stall = 1'b1;
        drive(1, 1, 3'd6, 2'b01, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_wreg",  {29'd0, bus.wb_write_reg}, 32'd5);
            chk("stl_wdata", {16'd0, bus.wb_write_data}, 32'h1234);
            chk("stl_ret",   bus.retired, 32'd4);
        end
        bus.flush = 1'b1;
        step();
        chk("flush_we",  {31'd0, bus.wb_regWrite}, 32'd0);
        chk("flush_ret", bus.retired, 32'd5);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // HALT retires
        drive(1, 1, 3'd2, 2'b00, 1, 0);
        step();
        drive(1, 1, 3'd4, 2'b00, 0, 0);
        chk("hlt_we",   {31'd0, bus.wb_regWrite}, 32'd0);
        chk("hlt_halt", {31'd0, bus.halt}, 32'd1);
        chk("hlt_dump", {31'd0, bus.createdump}, 32'd1);
        step();
        chk("hlt_dump_off", {31'd0, bus.createdump}, 32'd0);
        chk("hlt_halt2",    {31'd0, bus.halt}, 32'd1);
        chk("hlt_err",      {31'd0, bus.err}, 32'd0);
        chk("hlt_we2",      {31'd0, bus.wb_regWrite}, 32'd0);
        chk("hlt_ret",      bus.retired, 32'd6);
        step();
        chk("hlt_ret2",     bus.retired, 32'd6);
        chk("hlt_dump2",    {31'd0, bus.createdump}, 32'd0);

        // asynchronous reset mid-cycle
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_ret",  bus.retired, 32'd0);
        chk("arst_we",   {31'd0, bus.wb_regWrite}, 32'd0);
        chk("arst_halt", {31'd0, bus.halt}, 32'd0);
        step();
        rst = 1'b0;

        // halt and err together -> ERROR
        drive(1, 1, 3'd2, 2'b00, 1, 1);
        step();
        drive(0, 0, 3'd0, 2'b00, 0, 0);
        chk("he_err",  {31'd0, bus.err}, 32'd1);
        chk("he_halt", {31'd0, bus.halt}, 32'd1);
        chk("he_dump", {31'd0, bus.createdump}, 32'd0);
        step();
        chk("he_err2",  {31'd0, bus.err}, 32'd1);
        chk("he_dump2", {31'd0, bus.createdump}, 32'd0);
        chk("he_ret",   bus.retired, 32'd1);
        drive(1, 1, 3'd7, 2'b00, 0, 0);
        step();
        chk("he_we",   {31'd0, bus.wb_regWrite}, 32'd0);
        chk("he_ret2", bus.retired, 32'd1);

        // saturation on the narrow counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 3'(i), 2'b00, 0, 0);
            step();
        end
        drive(0, 0, 3'd0, 2'b00, 0, 0);
        step();
        chk("sat_ret32", bus.retired, 32'd17);
        chk("sat_ret4",  {28'd0, bus4.retired}, 32'hF);
        step();
        chk("sat_hold4", {28'd0, bus4.retired}, 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
